// File: rtl/music_sequencer.sv
// Two-channel note sequencer: walks the music ROM one entry per beat, gated by the
// tone generator's sample strobe, and drives note numbers plus per-channel rest flags.
//
// state  | meaning
// S_IDLE  | stopped; rests forced, next_val ignored
// S_PLAY  | counting strobes, sampling ROM at GAP_TICKS, articulating at beat wrap
// S_PAUSE | everything frozen, rests forced; cmd_play resumes
module music_sequencer #(
    parameter int ROM_AW    = 10,
    parameter int ROM_LEN   = 432,
    parameter int GAP_TICKS = 960
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              next_val,
    input  logic              cmd_play,
    input  logic              cmd_pause,
    input  logic              cmd_stop,
    input  logic              loop_en,
    input  logic [12:0]       beat_len,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [6:0]        note1,
    input  logic [6:0]        note2,
    output logic [6:0]        noteA,
    output logic [6:0]        noteB,
    output logic              restA,
    output logic              restB,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_PAUSE} state_t;

    localparam logic [12:0]       MIN_LEN   = 13'(GAP_TICKS + 2);
    localparam logic [12:0]       GAP       = 13'(GAP_TICKS);
    localparam logic [ROM_AW-1:0] LAST_ADDR = ROM_AW'(ROM_LEN - 1);

    state_t            state, state_d;
    logic              run_en;
    logic [12:0]       cnt, cnt_d;
    logic [12:0]       len_q, len_d;
    logic [ROM_AW-1:0] addr_d;
    logic [6:0]        note_a_d, note_b_d;
    logic              flag_a, flag_b, flag_a_d, flag_b_d;
    logic              done_d;
    logic [12:0]       beat_eff;

    // Release edge only arms run_en; the design starts acting on the following edge.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            run_en <= 1'b0;
        end else begin
            run_en <= 1'b1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            len_q    <= MIN_LEN;
            rom_addr <= '0;
            noteA    <= '0;
            noteB    <= '0;
            flag_a   <= 1'b1;
            flag_b   <= 1'b1;
            done     <= 1'b0;
        end else if (run_en) begin
            state    <= state_d;
            cnt      <= cnt_d;
            len_q    <= len_d;
            rom_addr <= addr_d;
            noteA    <= note_a_d;
            noteB    <= note_b_d;
            flag_a   <= flag_a_d;
            flag_b   <= flag_b_d;
            done     <= done_d;
        end
    end

    assign beat_eff = (beat_len > MIN_LEN) ? beat_len : MIN_LEN;

    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        len_d    = len_q;
        addr_d   = rom_addr;
        note_a_d = noteA;
        note_b_d = noteB;
        flag_a_d = flag_a;
        flag_b_d = flag_b;
        done_d   = 1'b0;

        case (state)
            S_IDLE: begin
                if (cmd_play && !cmd_pause && !cmd_stop) begin
                    state_d = S_PLAY;
                    len_d   = beat_eff;
                    cnt_d   = '0;
                    addr_d  = '0;
                end
            end
            S_PLAY: begin
                if (next_val) begin
                    if (cnt == GAP) begin
                        if (note1 != 7'd1) note_a_d = note1;
                        if (note2 != 7'd1) note_b_d = note2;
                        flag_a_d = (note1 == 7'd0);
                        flag_b_d = (note2 == 7'd0);
                        cnt_d    = cnt + 13'd1;
                        if (rom_addr != LAST_ADDR) begin
                            addr_d = rom_addr + 1'b1;
                        end else if (loop_en) begin
                            addr_d = '0;
                        end else begin
                            state_d  = S_IDLE;
                            done_d   = 1'b1;
                            addr_d   = '0;
                            cnt_d    = '0;
                            flag_a_d = 1'b1;
                            flag_b_d = 1'b1;
                        end
                    end else if (cnt == len_q - 13'd1) begin
                        // Short silence before the next entry unless it holds the tone.
                        cnt_d = '0;
                        len_d = beat_eff;
                        if (note1 != 7'd1) flag_a_d = 1'b1;
                        if (note2 != 7'd1) flag_b_d = 1'b1;
                    end else begin
                        cnt_d = cnt + 13'd1;
                    end
                end
                if (cmd_pause && !cmd_stop && state_d == S_PLAY) begin
                    state_d = S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (cmd_play && !cmd_pause && !cmd_stop) begin
                    state_d = S_PLAY;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (cmd_stop && state != S_IDLE) begin
            state_d  = S_IDLE;
            cnt_d    = '0;
            addr_d   = '0;
            flag_a_d = 1'b1;
            flag_b_d = 1'b1;
            done_d   = 1'b0;
        end
    end

    assign restA = (state == S_PLAY) ? flag_a : 1'b1;
    assign restB = (state == S_PLAY) ? flag_b : 1'b1;
    assign busy  = (state != S_IDLE);

endmodule

// File: tb/tb_music_sequencer.sv
// Directed bench for music_sequencer with a 4-entry ROM, short gap and a strobe every 5 clocks.
module tb_music_sequencer;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       next_val = 1'b0;
    logic       cmd_play = 1'b0;
    logic       cmd_pause = 1'b0;
    logic       cmd_stop = 1'b0;
    logic       loop_en = 1'b0;
    logic [12:0] beat_len = 13'd10;
    logic [1:0] rom_addr;
    logic [6:0] note1, note2;
    logic [6:0] noteA, noteB;
    logic       restA, restB, busy, done;

    int total = 0;
    int bad = 0;

    music_sequencer #(.ROM_AW(2), .ROM_LEN(4), .GAP_TICKS(4)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .next_val(next_val),
        .cmd_play(cmd_play), .cmd_pause(cmd_pause), .cmd_stop(cmd_stop),
        .loop_en(loop_en), .beat_len(beat_len), .rom_addr(rom_addr),
        .note1(note1), .note2(note2), .noteA(noteA), .noteB(noteB),
        .restA(restA), .restB(restB), .busy(busy), .done(done)
    );

    always #5 sys_clk = ~sys_clk;

    always_comb begin
        case (rom_addr)
            2'd0: begin note1 = 7'd60; note2 = 7'd0;  end
            2'd1: begin note1 = 7'd1;  note2 = 7'd64; end
            2'd2: begin note1 = 7'd0;  note2 = 7'd1;  end
            default: begin note1 = 7'd62; note2 = 7'd62; end
        endcase
    end

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic strobes(input int n);
        for (int i = 0; i < n; i++) begin
            next_val = 1'b1;
            @(negedge sys_clk);
            next_val = 1'b0;
            repeat (4) @(negedge sys_clk);
        end
    endtask

    task automatic cmd(input logic p, input logic pa, input logic s);
        cmd_play = p; cmd_pause = pa; cmd_stop = s;
        @(negedge sys_clk);
        cmd_play = 1'b0; cmd_pause = 1'b0; cmd_stop = 1'b0;
    endtask

    initial begin
        #12;
        chk("rst_restA", restA, 1);
        chk("rst_restB", restB, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_addr", rom_addr, 0);
        chk("rst_noteA", noteA, 0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (3) @(negedge sys_clk);

        // full song without loop
        cmd(1, 0, 0);
        chk("play_busy", busy, 1);
        chk("play_restA", restA, 1);
        strobes(4);
        chk("gap_restA", restA, 1);
        chk("gap_addr", rom_addr, 0);
        strobes(1);
        chk("s0_noteA", noteA, 60);
        chk("s0_restA", restA, 0);
        chk("s0_restB", restB, 1);
        chk("s0_addr", rom_addr, 1);
        strobes(5);
        chk("w1_restA", restA, 0);
        chk("w1_restB", restB, 1);
        strobes(5);
        chk("s1_noteA", noteA, 60);
        chk("s1_restA", restA, 0);
        chk("s1_noteB", noteB, 64);
        chk("s1_restB", restB, 0);
        chk("s1_addr", rom_addr, 2);
        strobes(5);
        chk("w2_restA", restA, 1);
        chk("w2_restB", restB, 0);
        strobes(5);
        chk("s2_restA", restA, 1);
        chk("s2_noteB", noteB, 64);
        chk("s2_restB", restB, 0);
        chk("s2_addr", rom_addr, 3);
        strobes(5);
        chk("w3_restA", restA, 1);
        chk("w3_restB", restB, 1);
        strobes(4);
        next_val = 1'b1;
        @(negedge sys_clk);
        next_val = 1'b0;
        chk("end_done", done, 1);
        chk("end_busy", busy, 0);
        chk("end_addr", rom_addr, 0);
        chk("end_noteA", noteA, 62);
        chk("end_restA", restA, 1);
        chk("end_restB", restB, 1);
        @(negedge sys_clk);
        chk("end_done_once", done, 0);
        repeat (3) @(negedge sys_clk);

        // looping
        loop_en = 1'b1;
        cmd(1, 0, 0);
        strobes(34);
        chk("loop_addr3", rom_addr, 3);
        strobes(1);
        chk("loop_addr0", rom_addr, 0);
        chk("loop_busy", busy, 1);
        chk("loop_done", done, 0);

        // pause at cnt=7
        strobes(2);
        cmd(0, 1, 0);
        chk("pause_restA", restA, 1);
        chk("pause_restB", restB, 1);
        chk("pause_busy", busy, 1);
        strobes(20);
        chk("pause_addr", rom_addr, 0);
        chk("pause_noteA", noteA, 62);
        cmd(1, 0, 0);
        chk("resume_restA", restA, 0);
        chk("resume_restB", restB, 0);
        strobes(7);
        chk("resume_w_restA", restA, 1);
        chk("resume_addr0", rom_addr, 0);
        strobes(1);
        chk("resume_noteA", noteA, 60);
        chk("resume_restB", restB, 1);
        chk("resume_addr1", rom_addr, 1);

        // stop wins over play
        cmd(1, 0, 1);
        chk("stop_busy", busy, 0);
        chk("stop_addr", rom_addr, 0);
        chk("stop_restA", restA, 1);
        chk("stop_noteA", noteA, 60);
        chk("stop_done", done, 0);
        cmd(0, 1, 0);
        chk("idle_pause_busy", busy, 0);

        // short beat clamps to GAP_TICKS+2 = 6
        beat_len = 13'd2;
        cmd(1, 0, 0);
        strobes(10);
        chk("short_addr1", rom_addr, 1);
        chk("short_restB", restB, 1);
        strobes(1);
        chk("short_addr2", rom_addr, 2);
        chk("short_noteB", noteB, 64);
        chk("short_restB2", restB, 0);

        // asynchronous reset mid-play
        #2 sys_rst_n = 1'b0;
        #1;
        chk("arst_noteA", noteA, 0);
        chk("arst_noteB", noteB, 0);
        chk("arst_restA", restA, 1);
        chk("arst_restB", restB, 1);
        chk("arst_busy", busy, 0);
        chk("arst_addr", rom_addr, 0);
        chk("arst_done", done, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/music_sequencer.md
MUSIC_SEQUENCER -- requirements
Module: music_sequencer

Interface
REQ-001 Parameter ROM_AW, default 10: ROM address width.
REQ-002 Parameter ROM_LEN, default 432: number of programmed ROM entries; address range 0..ROM_LEN-1.
REQ-003 Parameter GAP_TICKS, default 960: next_val strobes from beat start to note sampling (articulation gap).
REQ-004 sys_clk  in  1  system clock (100 MHz).
REQ-005 sys_rst_n  in  1  asynchronous active-low reset.
REQ-006 next_val  in  1  one-cycle 48 kHz sample strobe from the tone generator.
REQ-007 cmd_play  in  1  one-cycle pulse: start from IDLE, or resume from PAUSE.
REQ-008 cmd_pause  in  1  one-cycle pulse: freeze playback (PLAY only).
REQ-009 cmd_stop  in  1  one-cycle pulse: abort to IDLE.
REQ-010 loop_en  in  1  1 = wrap to entry 0 after the last entry.
REQ-011 beat_len  in  13  next_val strobes per ROM entry.
REQ-012 rom_addr  out  ROM_AW  music ROM address.
REQ-013 note1, note2  in  7 each  ROM data; 0 = rest, 1 = hold previous, 2..127 = note number; valid within 1 sys_clk of rom_addr.
REQ-014 noteA, noteB  out  7 each  note numbers to the tone generator.
REQ-015 restA, restB  out  1 each  1 = channel silent.
REQ-016 busy  out  1  1 in PLAY or PAUSE.
REQ-017 done  out  1  one-cycle pulse at non-looping end of song.

Function
REQ-018 States SHALL be IDLE, PLAY and PAUSE; all counter and state updates in PLAY occur only on sys_clk edges where next_val=1.
REQ-019 Command priority SHALL be stop > pause > play when asserted in the same cycle.
REQ-020 IDLE + cmd_play SHALL latch beat_len, clear cnt and rom_addr to 0, and enter PLAY on the next edge.
REQ-021 Latched beat length SHALL be max(beat_len, GAP_TICKS+2); it is re-latched only at each beat wrap.
REQ-022 In PLAY, each next_val SHALL increment the 13-bit counter cnt, except that cnt wraps to 0 when cnt == latched_len-1.
REQ-023 Sampling: on the next_val with cnt == GAP_TICKS, for each channel: a code other than 1 loads noteX; restX <= (code==0); rom_addr advances.
REQ-024 A code of 1 SHALL leave noteX unchanged and clear restX, holding the tone.
REQ-025 Advance from rom_addr == ROM_LEN-1 SHALL go to 0 if loop_en=1; otherwise enter IDLE and pulse done for 1 cycle, with restA=restB=1.
REQ-026 Articulation: on the next_val with the cnt wrap, restX SHALL be set to 1 for each channel whose current ROM code (at the already-advanced rom_addr) is not 1.
REQ-027 cmd_pause SHALL freeze cnt, rom_addr, noteA, noteB, the internal rest flags and latched_len; restA/restB outputs are forced to 1 while paused.
REQ-028 PAUSE + cmd_play SHALL return to PLAY with restX outputs restored to the internal flags and counting resumed from the frozen cnt.
REQ-029 cmd_stop from any state SHALL enter IDLE next edge with rom_addr=0, cnt=0, restA=restB=1; noteA and noteB are kept; done is not pulsed.
REQ-030 cmd_play in PLAY, cmd_pause outside PLAY, and cmd_stop in IDLE SHALL be ignored.
REQ-031 In IDLE, restA=restB=1 and busy=0; next_val has no effect.
REQ-032 A next_val coinciding with a command SHALL be processed in the state in effect before the command, with the command taking effect on the same edge.

Reset
REQ-033 On sys_rst_n=0, asynchronously: state IDLE, cnt=0, rom_addr=0, noteA=noteB=0, restA=restB=1, busy=0, done=0, latched_len=GAP_TICKS+2.
REQ-034 Reset deassertion SHALL be synchronized internally; first active edge is the second sys_clk edge after release.

Verification (GAP_TICKS=4, ROM_LEN=4, ROM = {(60,0),(1,64),(0,1),(62,62)}, beat_len=10, next_val every 5 cycles)
REQ-035 Play from IDLE -> restA stays 1 for 4 strobes; on 5th strobe noteA=60, restA=0, restB=1, rom_addr=1.
REQ-036 Continuation -> at beat wrap restA stays 0 and restB goes 1; after 4 more strobes noteA=60, restA=0, noteB=64, restB=0.
REQ-037 loop_en=0 -> after 4th entry sampled, done pulses once, busy=0, rom_addr=0, restA=restB=1; loop_en=1 -> rom_addr 3->0, busy stays 1.
REQ-038 Pause at cnt=7 for 100 cycles then play -> rests forced to 1 while paused, cnt resumes at 7, next sample after 7 more strobes.
REQ-039 Same-cycle cmd_stop+cmd_play in PLAY -> IDLE, rom_addr=0; beat_len=2 -> effective beat length 6.
REQ-040 sys_rst_n low mid-PLAY -> all outputs at reset values within the same cycle, without a clock edge.
